// File: rtl/tdoa_pkg.sv
// Shared constants, FSM state type and mic-pair geometry for the TDOA pair scheduler.
// Downstream blocks use pair_to_mics() to map a pair index back to its two microphones.
package tdoa_pkg;
    localparam int NUM_PAIRS = 15;
    localparam int NUM_LAGS  = 128;
    localparam int CORR_W    = 32;
    localparam int IDX_W     = 16;
    localparam int MAX_OUT   = 8;
    localparam int PAIR_W    = 4;
    localparam int LAG_W     = 7;
    localparam int OUT_W     = 4;
    localparam int MIC_W     = 3;

    localparam logic [PAIR_W-1:0] LAST_PAIR   = 4'd14;
    localparam logic [LAG_W:0]    LAGS_CNT    = 8'd128;
    localparam logic [LAG_W:0]    LAST_LAG    = 8'd127;
    localparam logic [OUT_W-1:0]  MAX_OUT_CNT = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        EMIT = 2'd2,
        FIN  = 2'd3
    } state_e;

    typedef struct packed {
        logic [MIC_W-1:0] mic_a;
        logic [MIC_W-1:0] mic_b;
    } mic_pair_t;

    function automatic mic_pair_t pair_to_mics(input logic [PAIR_W-1:0] pair);
        mic_pair_t m;
        case (pair)
            4'd0:    m = '{mic_a: 3'd0, mic_b: 3'd1};
            4'd1:    m = '{mic_a: 3'd0, mic_b: 3'd2};
            4'd2:    m = '{mic_a: 3'd0, mic_b: 3'd3};
            4'd3:    m = '{mic_a: 3'd0, mic_b: 3'd4};
            4'd4:    m = '{mic_a: 3'd0, mic_b: 3'd5};
            4'd5:    m = '{mic_a: 3'd1, mic_b: 3'd2};
            4'd6:    m = '{mic_a: 3'd1, mic_b: 3'd3};
            4'd7:    m = '{mic_a: 3'd1, mic_b: 3'd4};
            4'd8:    m = '{mic_a: 3'd1, mic_b: 3'd5};
            4'd9:    m = '{mic_a: 3'd2, mic_b: 3'd3};
            4'd10:   m = '{mic_a: 3'd2, mic_b: 3'd4};
            4'd11:   m = '{mic_a: 3'd2, mic_b: 3'd5};
            4'd12:   m = '{mic_a: 3'd3, mic_b: 3'd4};
            4'd13:   m = '{mic_a: 3'd3, mic_b: 3'd5};
            4'd14:   m = '{mic_a: 3'd4, mic_b: 3'd5};
            default: m = '{mic_a: 3'd0, mic_b: 3'd0};
        endcase
        return m;
    endfunction
endpackage

// File: rtl/tdoa_pair_scheduler_if.sv
// Correlator request/response and TDOA result bundle between the scheduler and its neighbours.
interface tdoa_pair_scheduler_if;
    import tdoa_pkg::*;

    logic                     req_valid;
    logic                     req_ready;
    logic [PAIR_W-1:0]        req_pair;
    logic [LAG_W-1:0]         req_lag;
    logic                     rsp_valid;
    logic signed [CORR_W-1:0] rsp_corr;
    logic                     tdoa_valid;
    logic [PAIR_W-1:0]        tdoa_pair;
    logic [IDX_W-1:0]         tdoa_idx;
    logic signed [CORR_W-1:0] tdoa_peak;

    modport master (
        output req_valid, req_pair, req_lag,
        input  req_ready,
        input  rsp_valid, rsp_corr,
        output tdoa_valid, tdoa_pair, tdoa_idx, tdoa_peak
    );

    modport slave (
        input  req_valid, req_pair, req_lag,
        output req_ready,
        output rsp_valid, rsp_corr,
        input  tdoa_valid, tdoa_pair, tdoa_idx, tdoa_peak
    );
endinterface

// File: rtl/tdoa_argmax_tracker.sv
// Signed running maximum with the lag index where it was first reached.
// A sample with clear high starts a new search regardless of the held peak.
module tdoa_argmax_tracker
    import tdoa_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     sample_valid,
    input  logic signed [CORR_W-1:0] sample,
    input  logic [LAG_W-1:0]         sample_idx,
    output logic signed [CORR_W-1:0] peak,
    output logic [LAG_W-1:0]         peak_idx
);
    logic signed [CORR_W-1:0] peak_q, peak_d;
    logic [LAG_W-1:0]         idx_q, idx_d;

    // Strict greater-than keeps the lowest lag on ties.
    always_comb begin
        peak_d = peak_q;
        idx_d  = idx_q;
        if (sample_valid && (clear || (sample > peak_q))) begin
            peak_d = sample;
            idx_d  = sample_idx;
        end else begin
            peak_d = peak_q;
            idx_d  = idx_q;
        end
    end

    // Peak/index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
            idx_q  <= '0;
        end else begin
            peak_q <= peak_d;
            idx_q  <= idx_d;
        end
    end

    assign peak     = peak_q;
    assign peak_idx = idx_q;
endmodule

// File: rtl/tdoa_pair_scheduler.sv
// Walks the shared correlator over all mic pairs and lags, emitting one peak-lag TDOA per pair.
// Issue for the next pair only starts after the current pair's result has been emitted.
module tdoa_pair_scheduler
    import tdoa_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic protocol_err,
    tdoa_pair_scheduler_if.master bus
);
    state_e            state_q, state_d;
    logic [PAIR_W-1:0] pair_q, pair_d;
    logic [PAIR_W-1:0] tdoa_pair_q, tdoa_pair_d;
    logic [LAG_W:0]    issued_q, issued_d;
    logic [LAG_W:0]    resp_q, resp_d;
    logic [OUT_W-1:0]  outst_q, outst_d;
    logic              req_valid_q, req_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tdoa_valid_q, tdoa_valid_d;
    logic              err_q, err_d;
    logic              hs_s, rsp_ok_s, last_rsp_s;
    logic signed [CORR_W-1:0] trk_peak_s;
    logic [LAG_W-1:0]         trk_idx_s;

    // Next-state, counter and registered-output computation.
    always_comb begin
        hs_s       = req_valid_q && bus.req_ready;
        rsp_ok_s   = bus.rsp_valid && (outst_q != 4'd0);
        last_rsp_s = rsp_ok_s && (resp_q == LAST_LAG);

        state_d      = state_q;
        pair_d       = pair_q;
        tdoa_pair_d  = tdoa_pair_q;
        tdoa_valid_d = 1'b0;
        issued_d     = hs_s ? (issued_q + 8'd1) : issued_q;
        resp_d       = rsp_ok_s ? (resp_q + 8'd1) : resp_q;

        // A response with nothing outstanding is dropped and latched as an error.
        if (bus.rsp_valid && (outst_q == 4'd0)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        case ({hs_s, rsp_ok_s})
            2'b10:   outst_d = outst_q + 4'd1;
            2'b01:   outst_d = outst_q - 4'd1;
            default: outst_d = outst_q;
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    pair_d   = 4'd0;
                    issued_d = 8'd0;
                    resp_d   = 8'd0;
                    outst_d  = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (last_rsp_s) begin
                    state_d      = EMIT;
                    tdoa_valid_d = 1'b1;
                    tdoa_pair_d  = pair_q;
                end else begin
                    state_d = RUN;
                end
            end
            EMIT: begin
                if (pair_q < LAST_PAIR) begin
                    state_d  = RUN;
                    pair_d   = pair_q + 4'd1;
                    issued_d = 8'd0;
                    resp_d   = 8'd0;
                end else begin
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_valid_d = (state_d == RUN) && (issued_d < LAGS_CNT) && (outst_d < MAX_OUT_CNT);
        busy_d      = (state_d == RUN) || (state_d == EMIT);
        done_d      = (state_d == FIN);
    end

    // Scheduler FSM, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pair_q       <= '0;
            tdoa_pair_q  <= '0;
            issued_q     <= '0;
            resp_q       <= '0;
            outst_q      <= '0;
            req_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tdoa_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pair_q       <= pair_d;
            tdoa_pair_q  <= tdoa_pair_d;
            issued_q     <= issued_d;
            resp_q       <= resp_d;
            outst_q      <= outst_d;
            req_valid_q  <= req_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            tdoa_valid_q <= tdoa_valid_d;
            err_q        <= err_d;
        end
    end

    // Responses arrive in request order, so the response count is the lag index.
    tdoa_argmax_tracker u_tracker (
        .clk          (clk),
        .rst          (rst),
        .clear        (resp_q == 8'd0),
        .sample_valid (rsp_ok_s),
        .sample       (bus.rsp_corr),
        .sample_idx   (resp_q[LAG_W-1:0]),
        .peak         (trk_peak_s),
        .peak_idx     (trk_idx_s)
    );

    assign bus.req_valid  = req_valid_q;
    assign bus.req_pair   = pair_q;
    assign bus.req_lag    = issued_q[LAG_W-1:0];
    assign bus.tdoa_valid = tdoa_valid_q;
    assign bus.tdoa_pair  = tdoa_pair_q;
    assign bus.tdoa_idx   = {{(IDX_W-LAG_W){1'b0}}, trk_idx_s};
    assign bus.tdoa_peak  = trk_peak_s;
    assign busy           = busy_q;
    assign done           = done_q;
    assign protocol_err   = err_q;
endmodule

// File: tb/tb_tdoa_pair_scheduler.sv
// Directed bench for tdoa_pair_scheduler with an in-order fixed-latency correlator model.
module tb_tdoa_pair_scheduler;
    import tdoa_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;
    logic protocol_err;
    int   n_checks = 0;
    int   n_pass   = 0;

    tdoa_pair_scheduler_if bus();

    tdoa_pair_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .protocol_err (protocol_err),
        .bus          (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: peak 500 at lag 5p; mode 1: flat -7; mode 2: peak 1000+p at lag 127-8p.
    function automatic logic signed [31:0] corr_val(input int mode, input int p, input int lag);
        case (mode)
            0:       return (lag == 5 * p) ? 32'sd500 : -lag;
            1:       return -32'sd7;
            default: return (lag == 127 - 8 * p) ? 1000 + p : lag % 16;
        endcase
    endfunction

    function automatic int exp_idx(input int mode, input int p);
        case (mode)
            0:       return 5 * p;
            1:       return 0;
            default: return 127 - 8 * p;
        endcase
    endfunction

    function automatic int exp_peak(input int mode, input int p);
        case (mode)
            0:       return 500;
            1:       return -7;
            default: return 1000 + p;
        endcase
    endfunction

    task automatic check_idle(input string pfx);
        check({pfx, "_busy"},       busy,           0);
        check({pfx, "_done"},       done,           0);
        check({pfx, "_req_valid"},  bus.req_valid,  0);
        check({pfx, "_req_pair"},   bus.req_pair,   0);
        check({pfx, "_req_lag"},    bus.req_lag,    0);
        check({pfx, "_tdoa_valid"}, bus.tdoa_valid, 0);
        check({pfx, "_tdoa_pair"},  bus.tdoa_pair,  0);
        check({pfx, "_tdoa_idx"},   bus.tdoa_idx,   0);
        check({pfx, "_tdoa_peak"},  bus.tdoa_peak,  0);
        check({pfx, "_perr"},       protocol_err,   0);
    endtask

    task automatic run_frame(input int lat, input int mode, input bit rand_rdy,
                             input bit extra_start, input bit abort);
        int cyc = 0, hs_pair = 0, hs_lag = 0, hs_tot = 0, rsp_n = 0;
        int n_tdoa = 0, n_done = 0, last_drive = 0, last_tdoa = -10;
        int viol = 0, seq_err = 0, outst, p;
        bit stalled = 1'b0, finished = 1'b0;
        int due_q[$];
        int pr_q[$];
        int lg_q[$];

        bus.req_ready = 1'b1;
        bus.rsp_valid = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_req_valid", bus.req_valid, 1);
        check("start_req_pair", bus.req_pair, 0);
        check("start_req_lag", bus.req_lag, 0);

        while (!finished && cyc < 20000) begin
            if (bus.tdoa_valid) begin
                check("tdoa_pair", bus.tdoa_pair, n_tdoa);
                check("tdoa_idx", bus.tdoa_idx, exp_idx(mode, n_tdoa));
                check("tdoa_peak", bus.tdoa_peak, exp_peak(mode, n_tdoa));
                check("tdoa_latency", cyc - last_drive, 1);
                n_tdoa++;
                last_tdoa = cyc;
            end
            if (cyc == last_tdoa + 1 && n_tdoa < NUM_PAIRS) begin
                check("next_pair_req", bus.req_valid, 1);
            end
            if (done) begin
                n_done++;
                check("done_latency", cyc - last_tdoa, 1);
                check("busy_at_done", busy, 0);
                finished = 1'b1;
            end

            outst = hs_tot - rsp_n;
            if (outst > MAX_OUT) viol++;
            if (outst >= MAX_OUT && bus.req_valid) viol++;
            if (outst == MAX_OUT) stalled = 1'b1;

            if (abort && hs_pair == 6 && hs_lag == 40) begin
                rst = 1'b1;
                bus.rsp_valid = 1'b0;
                @(negedge clk);
                check_idle("abort");
                rst = 1'b0;
                return;
            end

            bus.req_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.req_valid && bus.req_ready) begin
                if (bus.req_pair != 4'(hs_pair) || bus.req_lag != 7'(hs_lag)) seq_err++;
                due_q.push_back(cyc + lat);
                pr_q.push_back(hs_pair);
                lg_q.push_back(hs_lag);
                hs_tot++;
                hs_lag++;
                if (hs_lag == NUM_LAGS) begin
                    hs_lag = 0;
                    hs_pair++;
                end
            end

            if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                p = pr_q.pop_front();
                bus.rsp_valid = 1'b1;
                bus.rsp_corr  = corr_val(mode, p, lg_q[0]);
                if (lg_q[0] == NUM_LAGS - 1) last_drive = cyc;
                void'(lg_q.pop_front());
                rsp_n++;
            end else begin
                bus.rsp_valid = 1'b0;
            end

            start = extra_start && (cyc == 300);
            @(negedge clk);
            cyc++;
        end

        bus.rsp_valid = 1'b0;
        start = 1'b0;
        check("frame_finished", finished, 1);
        check("tdoa_count", n_tdoa, NUM_PAIRS);
        check("done_count", n_done, 1);
        check("req_sequence_errors", seq_err, 0);
        check("outstanding_violations", viol, 0);
        if (lat > MAX_OUT && !rand_rdy) check("stall_at_max_out", stalled, 1);
        repeat (3) @(negedge clk);
        check("idle_after_frame", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bus.req_ready = 1'b1;
        bus.rsp_valid = 1'b0;
        bus.rsp_corr  = '0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        run_frame(3, 0, 1'b0, 1'b1, 1'b0);
        check("perr_clean", protocol_err, 0);
        run_frame(3, 1, 1'b0, 1'b0, 1'b0);
        run_frame(12, 0, 1'b0, 1'b0, 1'b0);
        run_frame(12, 2, 1'b1, 1'b0, 1'b0);
        run_frame(3, 0, 1'b0, 1'b0, 1'b1);
        run_frame(5, 2, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        bus.rsp_valid = 1'b1;
        bus.rsp_corr  = 32'sd99;
        @(negedge clk);
        bus.rsp_valid = 1'b0;
        check("perr_set", protocol_err, 1);
        check("orphan_busy", busy, 0);
        run_frame(3, 1, 1'b0, 1'b0, 1'b0);
        check("perr_sticky", protocol_err, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("perr_cleared", protocol_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/tdoa_pair_scheduler.md
# tdoa_pair_scheduler

Sequences the shared cross-correlation engine over all 15 microphone pairs of the 6-mic gunshot array. For each pair it requests every lag, tracks the running peak of the returned correlation values, and emits one TDOA (peak lag index) per pair. It sits between the capture/trigger logic, which issues `start`, and the localisation solver, which consumes the `tdoa_*` stream.

## Interface
- NUM_PAIRS, 15, mic pairs per frame (6 choose 2)
- NUM_LAGS, 128, lags evaluated per pair
- CORR_W, 32, signed correlation width
- IDX_W, 16, TDOA index output width
- MAX_OUT, 8, maximum outstanding correlator requests
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame when idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last pair's TDOA is emitted
- req_valid  out  1  correlator request valid
- req_ready  in  1  correlator accepts the request
- req_pair  out  4  pair index of the request
- req_lag  out  7  lag index of the request
- rsp_valid  in  1  correlator result valid; responses arrive in request order with no backpressure
- rsp_corr  in  CORR_W  signed correlation value
- tdoa_valid  out  1  one-cycle pulse per pair
- tdoa_pair  out  4  pair index of the emitted result
- tdoa_idx  out  IDX_W  lag index of the peak, zero-extended
- tdoa_peak  out  CORR_W  signed peak value
- protocol_err  out  1  sticky; set on rsp_valid with nothing outstanding

## Operation
- FSM states: IDLE, RUN, EMIT, FIN.
- IDLE: on `start`, clear the pair counter, lag counter, response counter and outstanding counter, then go to RUN. `start` in any other state is ignored.
- RUN, issue side: `req_valid` = (issued lags < NUM_LAGS) and (outstanding < MAX_OUT). Each handshake (`req_valid && req_ready`) increments `req_lag`. `req_pair` holds the current pair.
- RUN, response side: each `rsp_valid` increments the response counter.
  - The first response of a pair loads the peak and sets index 0.
  - Each later response replaces the peak only if `rsp_corr` is strictly greater, signed. Ties therefore keep the lowest lag.
- Outstanding counter: +1 on handshake, -1 on response, unchanged when both occur in the same cycle.
- After the NUM_LAGS-th response, go to EMIT.
- EMIT: one cycle with `tdoa_valid` high and pair/idx/peak driven from the tracker.
  - If pair < NUM_PAIRS-1: increment pair, clear lag and response counters, return to RUN.
  - Otherwise go to FIN.
- FIN: one cycle with `done` high, then IDLE.
- Issue for pair p+1 never overlaps pair p; pipeline bubbles between pairs are accepted.
- `rsp_valid` while outstanding == 0, in any state: set `protocol_err` and ignore the data.
- Reset mid-frame: abort immediately and return to IDLE with all outputs at reset values. The correlator shares `rst`, so no stale responses follow.

## Timing
- Reset values: busy 0, done 0, req_valid 0, req_pair 0, req_lag 0, tdoa_valid 0, tdoa_pair 0, tdoa_idx 0, tdoa_peak 0, protocol_err 0.
- All outputs are registered.
- `start` at cycle 0 gives `busy` = 1 and `req_valid` = 1 with pair 0, lag 0 at cycle 1.
- `tdoa_valid` rises the cycle after the last response of the pair.
- `req_valid` for the next pair rises the cycle after `tdoa_valid`.
- `done` occurs the cycle after the final `tdoa_valid`; `busy` falls in the same cycle as `done`.
- Per-frame throughput with `req_ready` = 1 and fixed latency L ≤ MAX_OUT: 15 × (128 + L + 2) cycles approximately.

## Structure
- Package `tdoa_pkg`: NUM_PAIRS, NUM_LAGS, CORR_W, IDX_W, the FSM state enum, and the pair→(mic_a, mic_b) constant table used by downstream blocks.
- Sub-module `tdoa_argmax_tracker` holds the signed running max and index.
  - Inputs: clear, sample_valid, sample, sample_idx.
  - Outputs: peak, peak_idx.
- The scheduler owns the FSM, counters and handshakes.

## Test plan
- Correlator model with latency 3, `req_ready` = 1, pair p peak placed at lag 5p -> 15 `tdoa_valid` pulses with tdoa_idx = 0, 5, …, 70 in pair order, then one `done`.
- All correlations -7 for every lag -> tdoa_idx = 0 and tdoa_peak = -7 for every pair (tie keeps lowest lag; negative values handled as signed).
- `req_ready` random 50% with latency 12 -> outstanding never exceeds 8, `req_valid` stalls at 8, results still correct.
- Assert `rst` during pair 6 at lag 40 -> next cycle all outputs at reset values; a fresh `start` yields a complete 15-pair frame.
- Pulse `start` while busy, and inject `rsp_valid` in IDLE -> second start ignored; `protocol_err` goes to 1 and stays 1 until `rst`.
